// File: rtl/axis_ema_pkg.sv
// Shared types, constants and reference arithmetic for the EMA filter and its inverse.
package axis_ema_pkg;

  localparam int unsigned EMA_DATA_W = 32;
  localparam int unsigned EMA_KEEP_W = EMA_DATA_W / 8;
  localparam int unsigned EMA_SEED   = 1000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } ema_buf_state_t;

  // One AXI4-Stream beat as carried through the skid buffer.
  typedef struct packed {
    logic [EMA_DATA_W-1:0] data;
    logic [EMA_KEEP_W-1:0] keep;
    logic                  last;
  } ema_beat_t;

  // Forward filter: y = x/4 + 3p/4, with each term truncated, modulo 2^32.
  function automatic logic [EMA_DATA_W-1:0] ema_step(input logic [EMA_DATA_W-1:0] x,
                                                    input logic [EMA_DATA_W-1:0] p);
    return (x >> 2) + (p >> 2) + (p >> 1);
  endfunction

  // Inverse filter: recover x/4 exactly (mod 2^32) and rescale; low 2 bits are lost upstream.
  function automatic logic [EMA_DATA_W-1:0] ema_inv_step(input logic [EMA_DATA_W-1:0] y,
                                                        input logic [EMA_DATA_W-1:0] p);
    logic [EMA_DATA_W-1:0] d;
    d = y - (p >> 2) - (p >> 1);
    return d << 2;
  endfunction

endpackage

// File: rtl/axis_ema_inv_skid_buffer.sv
// Two-entry registered skid buffer: output register plus one skid slot, ready driven from a flop.
module axis_skid_buffer
  import axis_ema_pkg::*;
(
  input  logic      ACLK,
  input  logic      ARESETN,
  input  ema_beat_t s_beat,
  input  logic      s_valid,
  output logic      s_ready,
  output ema_beat_t m_beat,
  output logic      m_valid,
  input  logic      m_ready
);

  ema_buf_state_t state_q, state_d;
  ema_beat_t      out_q, out_d;
  ema_beat_t      skid_q, skid_d;
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic           in_fire_c;
  logic           out_fire_c;

  assign in_fire_c  = s_valid && ready_q;
  assign out_fire_c = valid_q && m_ready;

  // Next-state, register loads and the registered handshake flags.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire_c) begin
          out_d   = s_beat;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_fire_c && out_fire_c) begin
          out_d = s_beat;
        end else if (in_fire_c) begin
          skid_d  = s_beat;
          state_d = TWO;
        end else if (out_fire_c) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_fire_c) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    ready_d = (state_d != TWO);
    valid_d = (state_d != EMPTY);
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  assign s_ready = ready_q;
  assign m_beat  = out_q;
  assign m_valid = valid_q;

endmodule

// File: rtl/axis_ema_inv.sv
// AXI4-Stream inverse EMA: reconstructs x from y = x/4 + 3p/4 using the previous y as history.
// Optional build macro AXIS_EMA_INV_PKT_RESEED_EN reloads the history with SEED after each TLAST beat.
module axis_ema_inv
  import axis_ema_pkg::*;
#(
  parameter int unsigned SEED   = EMA_SEED,
  parameter int unsigned DATA_W = EMA_DATA_W
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [DATA_W-1:0]   S_AXIS_TDATA,
  input  logic [DATA_W/8-1:0] S_AXIS_TKEEP,
  input  logic                S_AXIS_TLAST,
  input  logic                S_AXIS_TVALID,
  output logic                S_AXIS_TREADY,
  output logic [DATA_W-1:0]   M_AXIS_TDATA,
  output logic [DATA_W/8-1:0] M_AXIS_TKEEP,
  output logic                M_AXIS_TLAST,
  output logic                M_AXIS_TVALID,
  input  logic                M_AXIS_TREADY
);

  logic [EMA_DATA_W-1:0] p_q, p_d;
  logic                  s_ready_c;
  logic                  accept_c;
  ema_beat_t             in_beat_c;
  ema_beat_t             out_beat_c;

  assign accept_c = S_AXIS_TVALID && s_ready_c;

  // Decoded beat presented to the buffer; sidebands ride along unchanged.
  always_comb begin
    in_beat_c      = '0;
    in_beat_c.data = ema_inv_step(EMA_DATA_W'(S_AXIS_TDATA), p_q);
    in_beat_c.keep = EMA_KEEP_W'(S_AXIS_TKEEP);
    in_beat_c.last = S_AXIS_TLAST;
  end

  // History advances only on an accepted input beat.
  always_comb begin
    p_d = p_q;
    if (accept_c) begin
`ifdef AXIS_EMA_INV_PKT_RESEED_EN
      p_d = S_AXIS_TLAST ? EMA_DATA_W'(SEED) : EMA_DATA_W'(S_AXIS_TDATA);
`else
      p_d = EMA_DATA_W'(S_AXIS_TDATA);
`endif
    end
  end

  // History register, returns to the seed on reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      p_q <= EMA_DATA_W'(SEED);
    end else begin
      p_q <= p_d;
    end
  end

  axis_skid_buffer u_skid (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_beat  (in_beat_c),
    .s_valid (S_AXIS_TVALID),
    .s_ready (s_ready_c),
    .m_beat  (out_beat_c),
    .m_valid (M_AXIS_TVALID),
    .m_ready (M_AXIS_TREADY)
  );

  assign S_AXIS_TREADY = s_ready_c;
  assign M_AXIS_TDATA  = DATA_W'(out_beat_c.data);
  assign M_AXIS_TKEEP  = (DATA_W/8)'(out_beat_c.keep);
  assign M_AXIS_TLAST  = out_beat_c.last;

endmodule
